// File: rtl/usb_in_arbiter_if.sv
// rtl/usb_in_arbiter_if.sv - requester and usb_cdc IN byte channel bundle for usb_in_arbiter
interface usb_in_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [8*NUM_REQ-1:0] req_data_i;
    logic [NUM_REQ-1:0]   req_valid_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic [7:0]           in_data_o;
    logic                 in_valid_o;
    logic                 in_ready_i;
    logic [NUM_REQ-1:0]   grant_o;

    // Arbiter side
    modport slave (
        input  req_data_i, req_valid_i, in_ready_i,
        output req_ready_o, in_data_o, in_valid_o, grant_o
    );

    // Environment side: requesters plus usb_cdc
    modport master (
        output req_data_i, req_valid_i, in_ready_i,
        input  req_ready_o, in_data_o, in_valid_o, grant_o
    );
endinterface

// File: rtl/usb_in_arbiter.sv
// rtl/usb_in_arbiter.sv - round-robin burst arbiter onto the usb_cdc IN byte channel (optional header: USB_IN_ARB_HEADER_EN)
module usb_in_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    usb_in_arbiter_if.slave  bus
);
    localparam int IDXW = $clog2(NUM_REQ);
    localparam int CNTW = $clog2(MAX_BURST + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAX_BURST - 1);
    localparam logic [IDXW-1:0] PTR_RST  = IDXW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HDR   = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDXW-1:0]      ptr_q, ptr_d;
    logic [IDXW-1:0]      gidx_q, gidx_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [7:0]           odata_q, odata_d;
    logic                 ovalid_q, ovalid_d;

    logic                 free;
    logic                 gvalid;
    logic [7:0]           gdata;
    logic                 found_hi, found_lo;
    logic [IDXW-1:0]      pick_hi, pick_lo, pick_idx;
    logic                 pick_any;
    logic                 load;
    logic [7:0]           load_data;

    assign free   = !ovalid_q || bus.in_ready_i;
    assign gvalid = |(bus.req_valid_i & grant_q);

    assign bus.req_ready_o = (state_q == S_BURST) ? (grant_q & {NUM_REQ{free}}) : '0;
    assign bus.grant_o     = grant_q;
    assign bus.in_data_o   = odata_q;
    assign bus.in_valid_o  = ovalid_q;

    // Mux the granted requester's byte using the one-hot grant
    always_comb begin
        gdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_q[k]) begin
                gdata = gdata | bus.req_data_i[k*8 +: 8];
            end
        end
    end

    // Round-robin pick: lowest valid index above ptr, else lowest valid index at or below ptr
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid_i[k]) begin
                if (IDXW'(k) > ptr_q) begin
                    found_hi = 1'b1;
                    pick_hi  = IDXW'(k);
                end else begin
                    found_lo = 1'b1;
                    pick_lo  = IDXW'(k);
                end
            end
        end
        pick_any = found_hi || found_lo;
        pick_idx = found_hi ? pick_hi : pick_lo;
    end

    // Next-state: grant selection, burst counting, release and output register load
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        load_data = gdata;
        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (pick_any) begin
                    gidx_d  = pick_idx;
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    cnt_d   = '0;
`ifdef USB_IN_ARB_HEADER_EN
                    state_d = S_HDR;
`else
                    state_d = S_BURST;
`endif
                end
            end
`ifdef USB_IN_ARB_HEADER_EN
            S_HDR: begin
                if (free) begin
                    load      = 1'b1;
                    load_data = {4'hA, 4'(gidx_q)};
                    state_d   = S_BURST;
                end
            end
`endif
            S_BURST: begin
                if (!gvalid) begin
                    state_d = S_IDLE;
                    ptr_d   = gidx_q;
                    grant_d = '0;
                end else if (free) begin
                    load  = 1'b1;
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_IDLE;
                        ptr_d   = gidx_q;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
        odata_d  = load ? load_data : odata_q;
        ovalid_d = load ? 1'b1 : (bus.in_ready_i ? 1'b0 : ovalid_q);
    end

    // State and output register; reset discards any held byte
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            ptr_q    <= PTR_RST;
            gidx_q   <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
        end
    end
endmodule

// File: tb/tb_usb_in_arbiter.sv
// tb/tb_usb_in_arbiter.sv - directed self-checking bench for usb_in_arbiter
module tb_usb_in_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    usb_in_arbiter_if #(.NUM_REQ(2)) bus2 ();
    usb_in_arbiter_if #(.NUM_REQ(3)) bus3 ();

    usb_in_arbiter #(.NUM_REQ(2), .MAX_BURST(8)) dut2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus2.slave)
    );

    usb_in_arbiter #(.NUM_REQ(3), .MAX_BURST(8)) dut3 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus3.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int         sel;
    int         len  [3];
    int         pos  [3];
    int         step [3];
    logic [7:0] base [3];
    int         stall_lo, stall_hi;
    logic [7:0] got [$];

    logic [2:0] grant_log [64];
    logic [2:0] ready_log [64];
    logic       valid_log [64];
    logic [7:0] data_log  [64];

    task automatic zero_inputs();
        bus2.req_valid_i = '0;
        bus2.req_data_i  = '0;
        bus2.in_ready_i  = 1'b1;
        bus3.req_valid_i = '0;
        bus3.req_data_i  = '0;
        bus3.in_ready_i  = 1'b1;
    endtask

    task automatic clear_sources();
        for (int k = 0; k < 3; k++) begin
            len[k]  = 0;
            pos[k]  = 0;
            step[k] = 1;
            base[k] = 8'h00;
        end
        stall_lo = 0;
        stall_hi = 0;
        got.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sel = 2;
        clear_sources();
        zero_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One iteration per clock: drive sources at negedge, sample, then advance accepted sources
    task automatic run(input int n);
        logic [2:0] v;
        logic [2:0] rdy;
        logic [7:0] d [3];
        logic       ir;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                v[k] = (pos[k] < len[k]);
                d[k] = base[k] + 8'(step[k] * pos[k]);
            end
            ir = !(c >= stall_lo && c < stall_hi);
            bus2.req_valid_i = (sel == 2) ? v[1:0] : 2'b00;
            bus2.req_data_i  = {d[1], d[0]};
            bus3.req_valid_i = (sel == 3) ? v : 3'b000;
            bus3.req_data_i  = {d[2], d[1], d[0]};
            bus2.in_ready_i  = ir;
            bus3.in_ready_i  = ir;
            #1;
            if (sel == 2) begin
                grant_log[c] = {1'b0, bus2.grant_o};
                ready_log[c] = {1'b0, bus2.req_ready_o};
                valid_log[c] = bus2.in_valid_o;
                data_log[c]  = bus2.in_data_o;
            end else begin
                grant_log[c] = bus3.grant_o;
                ready_log[c] = bus3.req_ready_o;
                valid_log[c] = bus3.in_valid_o;
                data_log[c]  = bus3.in_data_o;
            end
            if (valid_log[c] && ir) got.push_back(data_log[c]);
            rdy = ready_log[c];
            @(posedge clk);
            for (int k = 0; k < 3; k++) begin
                if (v[k] && rdy[k]) pos[k]++;
            end
        end
    endtask

    task automatic test_reset();
        zero_inputs();
        rst = 1'b0;
        #2 rst = 1'b1;
        #2;
        n_checks++;
        if (bus2.in_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_in_valid: got %b expected 0", bus2.in_valid_o); end
        n_checks++;
        if (bus2.in_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_in_data: got %h expected 00", bus2.in_data_o); end
        n_checks++;
        if (bus2.grant_o !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b expected 00", bus2.grant_o); end
        n_checks++;
        if (bus2.req_ready_o !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", bus2.req_ready_o); end
        n_checks++;
        if (bus3.grant_o !== 3'b000) begin n_fail++; $display("FAIL reset_grant3: got %b expected 000", bus3.grant_o); end
        do_reset();
    endtask

    task automatic test_single();
        logic [7:0] exp_b;
        do_reset();
        len[0] = 3; base[0] = 8'h01;
        run(8);
        n_checks++;
        if (grant_log[0] !== 3'b000) begin n_fail++; $display("FAIL single_grant_c0: got %b expected 000", grant_log[0]); end
        n_checks++;
        if (grant_log[1] !== 3'b001) begin n_fail++; $display("FAIL single_grant_c1: got %b expected 001", grant_log[1]); end
        n_checks++;
        if (ready_log[1] !== 3'b001) begin n_fail++; $display("FAIL single_ready_c1: got %b expected 001", ready_log[1]); end
        for (int c = 2; c < 5; c++) begin
            exp_b = 8'(c - 1);
            n_checks++;
            if (valid_log[c] !== 1'b1 || data_log[c] !== exp_b) begin
                n_fail++; $display("FAIL single_out_c%0d: got v=%b d=%h expected v=1 d=%h", c, valid_log[c], data_log[c], exp_b);
            end
        end
        n_checks++;
        if (grant_log[5] !== 3'b000) begin n_fail++; $display("FAIL single_grant_drained: got %b expected 000", grant_log[5]); end
        n_checks++;
        if (valid_log[5] !== 1'b0) begin n_fail++; $display("FAIL single_valid_after: got %b expected 0", valid_log[5]); end
        n_checks++;
        if (got.size() !== 3) begin n_fail++; $display("FAIL single_count: got %0d expected 3", got.size()); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_b;
        do_reset();
        len[0] = 24; base[0] = 8'h10;
        len[1] = 24; base[1] = 8'h20;
        run(28);
        n_checks++;
        if (got.size() !== 24) begin n_fail++; $display("FAIL rr_count: got %0d expected 24", got.size()); end
        for (int i = 0; i < 24 && i < got.size(); i++) begin
            if (i < 8)       exp_b = 8'h10 + 8'(i);
            else if (i < 16) exp_b = 8'h20 + 8'(i - 8);
            else             exp_b = 8'h18 + 8'(i - 16);
            n_checks++;
            if (got[i] !== exp_b) begin n_fail++; $display("FAIL rr_byte%0d: got %h expected %h", i, got[i], exp_b); end
        end
        n_checks++;
        if (grant_log[9] !== 3'b000) begin n_fail++; $display("FAIL rr_bubble1_grant: got %b expected 000", grant_log[9]); end
        n_checks++;
        if (grant_log[10] !== 3'b010) begin n_fail++; $display("FAIL rr_grant_req1: got %b expected 010", grant_log[10]); end
        n_checks++;
        if (valid_log[10] !== 1'b0) begin n_fail++; $display("FAIL rr_bubble1_valid: got %b expected 0", valid_log[10]); end
        n_checks++;
        if (grant_log[18] !== 3'b000) begin n_fail++; $display("FAIL rr_bubble2_grant: got %b expected 000", grant_log[18]); end
        n_checks++;
        if (grant_log[19] !== 3'b001) begin n_fail++; $display("FAIL rr_grant_req0_again: got %b expected 001", grant_log[19]); end
    endtask

    task automatic test_stall();
        do_reset();
        len[0] = 8; base[0] = 8'h40;
        stall_lo = 4; stall_hi = 9;
        run(20);
        for (int c = 4; c < 9; c++) begin
            n_checks++;
            if (valid_log[c] !== 1'b1 || data_log[c] !== 8'h42 || ready_log[c] !== 3'b000) begin
                n_fail++; $display("FAIL stall_c%0d: got v=%b d=%h rdy=%b expected v=1 d=42 rdy=000", c, valid_log[c], data_log[c], ready_log[c]);
            end
        end
        n_checks++;
        if (got.size() !== 8) begin n_fail++; $display("FAIL stall_count: got %0d expected 8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== 8'h40 + 8'(i)) begin n_fail++; $display("FAIL stall_byte%0d: got %h expected %h", i, got[i], 8'h40 + 8'(i)); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        len[0] = 8; base[0] = 8'h60;
        len[1] = 8; base[1] = 8'h70;
        run(5);
        n_checks++;
        if (grant_log[4] !== 3'b001) begin n_fail++; $display("FAIL rstmid_pre_grant: got %b expected 001", grant_log[4]); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus2.in_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_valid: got %b expected 0", bus2.in_valid_o); end
        n_checks++;
        if (bus2.in_data_o !== 8'h00) begin n_fail++; $display("FAIL rstmid_in_data: got %h expected 00", bus2.in_data_o); end
        n_checks++;
        if (bus2.grant_o !== 2'b00) begin n_fail++; $display("FAIL rstmid_grant: got %b expected 00", bus2.grant_o); end
        n_checks++;
        if (bus2.req_ready_o !== 2'b00) begin n_fail++; $display("FAIL rstmid_req_ready: got %b expected 00", bus2.req_ready_o); end
        clear_sources();
        zero_inputs();
        len[0] = 8; base[0] = 8'h80;
        len[1] = 8; base[1] = 8'h90;
        @(negedge clk);
        rst = 1'b0;
        run(4);
        n_checks++;
        if (grant_log[1] !== 3'b001) begin n_fail++; $display("FAIL rstmid_first_grant: got %b expected 001", grant_log[1]); end
        n_checks++;
        if (valid_log[2] !== 1'b1 || data_log[2] !== 8'h80) begin
            n_fail++; $display("FAIL rstmid_first_byte: got v=%b d=%h expected v=1 d=80", valid_log[2], data_log[2]);
        end
    endtask

    task automatic test_num_req3();
        logic [7:0] exp_q [7];
        exp_q = '{8'h30, 8'h31, 8'h32, 8'hC0, 8'hC1, 8'h33, 8'h34};
        do_reset();
        sel = 3;
        len[0] = 3; base[0] = 8'h30;
        run(6);
        n_checks++;
        if (grant_log[1] !== 3'b001) begin n_fail++; $display("FAIL r3_first_grant: got %b expected 001", grant_log[1]); end
        len[0] = 5;
        len[2] = 2; base[2] = 8'hC0;
        run(10);
        n_checks++;
        if (grant_log[1] !== 3'b100) begin n_fail++; $display("FAIL r3_grant_req2: got %b expected 100", grant_log[1]); end
        n_checks++;
        if (grant_log[5] !== 3'b001) begin n_fail++; $display("FAIL r3_grant_req0: got %b expected 001", grant_log[5]); end
        n_checks++;
        if (got.size() !== 7) begin n_fail++; $display("FAIL r3_count: got %0d expected 7", got.size()); end
        for (int i = 0; i < 7 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL r3_byte%0d: got %h expected %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_header();
        logic [7:0] exp_q [3];
        exp_q = '{8'hA1, 8'h55, 8'h66};
        do_reset();
        len[1] = 2; base[1] = 8'h55; step[1] = 8'h11;
        run(8);
        n_checks++;
        if (grant_log[1] !== 3'b010) begin n_fail++; $display("FAIL hdr_grant: got %b expected 010", grant_log[1]); end
        n_checks++;
        if (ready_log[1] !== 3'b000) begin n_fail++; $display("FAIL hdr_ready_c1: got %b expected 000", ready_log[1]); end
        n_checks++;
        if (ready_log[2] !== 3'b010) begin n_fail++; $display("FAIL hdr_ready_c2: got %b expected 010", ready_log[2]); end
        n_checks++;
        if (valid_log[2] !== 1'b1 || data_log[2] !== 8'hA1) begin
            n_fail++; $display("FAIL hdr_byte_c2: got v=%b d=%h expected v=1 d=a1", valid_log[2], data_log[2]);
        end
        n_checks++;
        if (got.size() !== 3) begin n_fail++; $display("FAIL hdr_count: got %0d expected 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL hdr_byte%0d: got %h expected %h", i, got[i], exp_q[i]); end
        end
    endtask

    initial begin
        sel = 2;
        clear_sources();
        test_reset();
`ifdef USB_IN_ARB_HEADER_EN
        test_header();
`else
        test_single();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_num_req3();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
